// File: rtl/key_conditioner.sv
// Pushbutton conditioner for the tug-of-war game: turns each raw, bouncy, active-low key
// into exactly one single-cycle move pulse per press, with auto-repeat lockout.

module key_conditioner_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse,
    output logic held
);

    typedef enum logic [2:0] {ARM, IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   reached;
    logic                   fire;

    // Synchroniser resets to "released" so a key held through reset reads as a fresh low.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;
    assign reached = (cnt_inc == CNT_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARM;
            cnt_q   <= '0;
            pulse   <= 1'b0;
            held    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= fire;
            held    <= (state_q == HELD) || (state_q == REL_WAIT);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        unique case (state_q)
            ARM: begin
                // Must see a stable release before arming: no phantom press out of reset.
                if (!s) begin
                    cnt_d = '0;
                end else if (reached) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            IDLE: begin
                if (!s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (reached) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (s) begin
                    state_d = REL_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            REL_WAIT: begin
                // A bounce back low returns to HELD silently: still the same press.
                if (!s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (reached) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ARM;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

module key_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    input  logic enable,
    output logic L,
    output logic R,
    output logic l_held,
    output logic r_held
);

    logic pulse_l, pulse_r;

    key_conditioner_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_left (
        .clk  (clk),
        .reset(reset),
        .key_n(key_l_n),
        .pulse(pulse_l),
        .held (l_held)
    );

    key_conditioner_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_right (
        .clk  (clk),
        .reset(reset),
        .key_n(key_r_n),
        .pulse(pulse_r),
        .held (r_held)
    );

    // Enable only gates the outputs; a press completed while disabled is simply lost.
    assign L = pulse_l & enable;
    assign R = pulse_r & enable;

endmodule

// File: tb/tb_key_conditioner.sv
// Cycle-accurate vector bench for key_conditioner: each record is applied before one rising
// edge and its expected {L,R,l_held,r_held} is compared in the cycle after that edge.

module tb_key_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic key_l_n, key_r_n, enable;
    logic L, R, l_held, r_held;

    key_conditioner dut (
        .clk    (clk),
        .reset  (reset),
        .key_l_n(key_l_n),
        .key_r_n(key_r_n),
        .enable (enable),
        .L      (L),
        .R      (R),
        .l_held (l_held),
        .r_held (r_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       rst;
        logic       kl;
        logic       kr;
        logic       en;
        logic [3:0] exp;   // {L, R, l_held, r_held}
    } vec_t;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] PL   = 4'b1000;
    localparam logic [3:0] PR   = 4'b0100;
    localparam logic [3:0] PLR  = 4'b1100;
    localparam logic [3:0] HL   = 4'b0010;
    localparam logic [3:0] HR   = 4'b0001;
    localparam logic [3:0] HLR  = 4'b0011;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input string tag, input logic rst, input logic kl, input logic kr,
                       input logic en, input logic [3:0] exp, input int n);
        vec_t v;
        v.tag = tag; v.rst = rst; v.kl = kl; v.kr = kr; v.en = en; v.exp = exp;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got {L,R,lh,rh}=%b, expected %b", name, actual, expected);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, e;

        // Reset state, then let both channels arm with keys released.
        add("rst", 0, 1, 1, 1, NONE, 3);
        add("arm", 1, 1, 1, 1, NONE, 8);

        // 1: clean left press, 20 cycles.
        add("t1_clean", 1, 0, 1, 1, NONE, 5);
        add("t1_clean", 1, 0, 1, 1, PL,   1);
        add("t1_clean", 1, 0, 1, 1, HL,   14);
        add("t1_clean", 1, 1, 1, 1, HL,   6);
        add("t1_clean", 1, 1, 1, 1, NONE, 4);

        // 2: press bounce 0,1,0,1,0 then stable low.
        add("t2_bounce", 1, 0, 1, 1, NONE, 1);
        add("t2_bounce", 1, 1, 1, 1, NONE, 1);
        add("t2_bounce", 1, 0, 1, 1, NONE, 1);
        add("t2_bounce", 1, 1, 1, 1, NONE, 1);
        add("t2_bounce", 1, 0, 1, 1, NONE, 5);
        add("t2_bounce", 1, 0, 1, 1, PL,   1);
        add("t2_bounce", 1, 0, 1, 1, HL,   10);
        add("t2_bounce", 1, 1, 1, 1, HL,   6);
        add("t2_bounce", 1, 1, 1, 1, NONE, 4);

        // 3: release bounce while held: no second pulse, l_held stays up.
        add("t3_relbnc", 1, 0, 1, 1, NONE, 5);
        add("t3_relbnc", 1, 0, 1, 1, PL,   1);
        add("t3_relbnc", 1, 0, 1, 1, HL,   6);
        add("t3_relbnc", 1, 1, 1, 1, HL,   2);
        add("t3_relbnc", 1, 0, 1, 1, HL,   4);
        add("t3_relbnc", 1, 1, 1, 1, HL,   6);
        add("t3_relbnc", 1, 1, 1, 1, NONE, 4);

        // 4: right key pressed mid-debounce, reset, held through it; then release and re-press.
        add("t4_rsthold", 1, 1, 0, 1, NONE, 3);
        add("t4_rsthold", 0, 1, 0, 1, NONE, 2);
        add("t4_rsthold", 1, 1, 0, 1, NONE, 30);
        add("t4_rsthold", 1, 1, 1, 1, NONE, 10);
        add("t4_rsthold", 1, 1, 0, 1, NONE, 5);
        add("t4_rsthold", 1, 1, 0, 1, PR,   1);
        add("t4_rsthold", 1, 1, 0, 1, HR,   4);
        add("t4_rsthold", 1, 1, 1, 1, HR,   6);
        add("t4_rsthold", 1, 1, 1, 1, NONE, 4);

        // 5: simultaneous presses.
        add("t5_both", 1, 0, 0, 1, NONE, 5);
        add("t5_both", 1, 0, 0, 1, PLR,  1);
        add("t5_both", 1, 0, 0, 1, HLR,  4);
        add("t5_both", 1, 1, 1, 1, HLR,  6);
        add("t5_both", 1, 1, 1, 1, NONE, 4);

        // 6: press while disabled is lost; enabling mid-hold does not revive it.
        add("t6_enable", 1, 0, 1, 0, NONE, 6);
        add("t6_enable", 1, 0, 1, 0, HL,   2);
        add("t6_enable", 1, 0, 1, 1, HL,   7);
        add("t6_enable", 1, 1, 1, 1, HL,   6);
        add("t6_enable", 1, 1, 1, 1, NONE, 4);
        add("t6_enable", 1, 0, 1, 1, NONE, 5);
        add("t6_enable", 1, 0, 1, 1, PL,   1);
        add("t6_enable", 1, 0, 1, 1, HL,   4);
        add("t6_enable", 1, 1, 1, 1, HL,   6);
        add("t6_enable", 1, 1, 1, 1, NONE, 4);

        // 7: boundary: 3 low samples rejected, exactly 4 accepted.
        add("t7_short3", 1, 0, 1, 1, NONE, 3);
        add("t7_short3", 1, 1, 1, 1, NONE, 7);
        add("t7_exact4", 1, 0, 1, 1, NONE, 4);
        add("t7_exact4", 1, 1, 1, 1, NONE, 1);
        add("t7_exact4", 1, 1, 1, 1, PL,   1);
        add("t7_exact4", 1, 1, 1, 1, HL,   4);
        add("t7_exact4", 1, 1, 1, 1, NONE, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            v       = vecs[i];
            reset   = v.rst;
            key_l_n = v.kl;
            key_r_n = v.kr;
            enable  = v.en;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty[%0d]: got no entry, expected one", i);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s[%0d]", e.tag, i), {L, R, l_held, r_held}, e.exp);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
